// File: rtl/bus_timer.sv
// Bus-mapped down-counting timer with a prescaler. It generates periodic or one-shot
// interrupts and has four word registers: CTRL, LOAD, COUNT and STATUS.
module bus_timer #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [3:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        irq_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mask_lanes(input logic [31:0] data,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  logic               en, ie, reload, pend;
  logic [PRESC_W-1:0] presc, pcnt;
  logic [WIDTH-1:0]   load, count;

  logic [31:0] ctrl_word, load_word, count_word, status_word, rd_word;
  logic [31:0] wr_ctrl, wr_load, wr_count;
  logic        xfer, wr_xfer, rd_xfer;
  logic        ctrl_we, load_we, count_we, status_we;
  logic        tick, expire, clr_pend;
  logic        unused_bits;

  always_comb begin
    ctrl_word              = '0;
    ctrl_word[0]           = en;
    ctrl_word[1]           = ie;
    ctrl_word[2]           = reload;
    ctrl_word[8 +: PRESC_W] = presc;
    load_word              = '0;
    load_word[WIDTH-1:0]   = load;
    count_word             = '0;
    count_word[WIDTH-1:0]  = count;
    status_word            = '0;
    status_word[0]         = pend;
    case (adr_i[3:2])
      REG_CTRL:  rd_word = ctrl_word;
      REG_LOAD:  rd_word = load_word;
      REG_COUNT: rd_word = count_word;
      default:   rd_word = status_word;
    endcase
  end

  // A transfer happens on the edge that raises ack; a held strobe acks every other cycle.
  assign xfer      = stb_i & ~ack_o;
  assign wr_xfer   = xfer & we_i;
  assign rd_xfer   = xfer & ~we_i;
  assign ctrl_we   = wr_xfer && (adr_i[3:2] == REG_CTRL);
  assign load_we   = wr_xfer && (adr_i[3:2] == REG_LOAD);
  assign count_we  = wr_xfer && (adr_i[3:2] == REG_COUNT);
  assign status_we = wr_xfer && (adr_i[3:2] == REG_STATUS);

  assign wr_ctrl  = merge_lanes(ctrl_word, dat_i, sel_i);
  assign wr_load  = merge_lanes(load_word, dat_i, sel_i);
  assign wr_count = merge_lanes(count_word, dat_i, sel_i);

  assign tick     = en && (pcnt == presc);
  assign expire   = tick && (count == '0);
  assign clr_pend = status_we & sel_i[0] & dat_i[0];

  assign irq_o       = pend & ie;
  assign unused_bits = ^{adr_i[1:0], wr_ctrl, wr_load, wr_count};

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      dat_o  <= '0;
      en     <= 1'b0;
      ie     <= 1'b0;
      reload <= 1'b0;
      presc  <= '0;
      pcnt   <= '0;
      load   <= '0;
      count  <= '0;
      pend   <= 1'b0;
    end else begin
      ack_o <= xfer;
      if (rd_xfer) dat_o <= mask_lanes(rd_word, sel_i);

      if (ctrl_we && wr_ctrl[0] && !en) pcnt <= '0;
      else if (en)                      pcnt <= tick ? '0 : pcnt + 1'b1;

      // A bus write to COUNT overrides whatever the tick would have done.
      if (count_we)
        count <= wr_count[WIDTH-1:0];
      else if (tick) begin
        if (count != '0) count <= count - 1'b1;
        else if (reload) count <= load;
      end

      if (load_we) load <= wr_load[WIDTH-1:0];

      if (ctrl_we) begin
        en     <= wr_ctrl[0];
        ie     <= wr_ctrl[1];
        reload <= wr_ctrl[2];
        presc  <= wr_ctrl[8 +: PRESC_W];
      end else if (expire && !reload) begin
        en <= 1'b0;
      end

      if (expire)        pend <= 1'b1;
      else if (clr_pend) pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: reset, periodic and one-shot counting, byte lanes,
// set-versus-clear priority of PEND, and the bus handshake.
module tb_bus_timer;
  logic        clk, rst_i, we_i, stb_i, ack_o, irq_o;
  logic [3:0]  adr_i, sel_i;
  logic [31:0] dat_i, dat_o;
  int pass_cnt = 0;
  int total_cnt = 0;

  bus_timer #(.WIDTH(32), .PRESC_W(8)) dut (
    .clk(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o), .dat_o(dat_o), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; stb_i = 1'b0; we_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    adr_i = a; dat_i = d; sel_i = s; we_i = 1'b1; stb_i = 1'b1;
    @(negedge clk);
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [3:0] s,
                          output logic [31:0] d, output logic ak);
    @(negedge clk);
    adr_i = a; sel_i = s; we_i = 1'b0; stb_i = 1'b1;
    @(negedge clk);
    d = dat_o; ak = ack_o;
    stb_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic ak;
    do_reset();
    total_cnt++; if (ack_o !== 1'b0) $display("FAIL rst_ack: got %0b want 0", ack_o); else pass_cnt++;
    total_cnt++; if (dat_o !== 32'h0) $display("FAIL rst_dat: got %h want 0", dat_o); else pass_cnt++;
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL rst_irq: got %0b want 0", irq_o); else pass_cnt++;
    bus_write(4'h4, 32'd50, 4'hF);
    bus_write(4'h8, 32'd1, 4'hF);
    bus_write(4'h0, 32'h7, 4'hF);
    repeat (4) @(negedge clk);
    total_cnt++; if (irq_o !== 1'b1) $display("FAIL rst_pre_irq: got %0b want 1", irq_o); else pass_cnt++;
    adr_i = 4'h8; sel_i = 4'hF; we_i = 1'b0; stb_i = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (ack_o !== 1'b1) $display("FAIL rst_pre_ack: got %0b want 1", ack_o); else pass_cnt++;
    total_cnt++; if (dat_o !== 32'd48) $display("FAIL rst_pre_dat: got %0d want 48", dat_o); else pass_cnt++;
    rst_i = 1'b1; #1;
    total_cnt++; if (ack_o !== 1'b0) $display("FAIL rst_async_ack: got %0b want 0", ack_o); else pass_cnt++;
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL rst_async_irq: got %0b want 0", irq_o); else pass_cnt++;
    total_cnt++; if (dat_o !== 32'h0) $display("FAIL rst_async_dat: got %h want 0", dat_o); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ack_o !== 1'b0) $display("FAIL rst_held_ack: got %0b want 0", ack_o); else pass_cnt++;
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (ack_o !== 1'b1) $display("FAIL rst_release_ack: got %0b want 1", ack_o); else pass_cnt++;
    total_cnt++; if (dat_o !== 32'h0) $display("FAIL rst_release_dat: got %h want 0", dat_o); else pass_cnt++;
    @(negedge clk);
    stb_i = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus_read(4'(r * 4), 4'hF, d, ak);
      total_cnt++;
      if (ak !== 1'b1 || d !== 32'h0) $display("FAIL rst_read_reg%0d: got ack=%0b dat=%h want ack=1 dat=0", r, ak, d);
      else pass_cnt++;
    end
  endtask

  task automatic test_periodic();
    do_reset();
    bus_write(4'h4, 32'd4, 4'hF);
    bus_write(4'h8, 32'd4, 4'hF);
    bus_write(4'h0, 32'h7, 4'hF);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (irq_o !== (i == 5)) $display("FAIL per_irq_c%0d: got %0b want %0b", i, irq_o, (i == 5));
      else pass_cnt++;
    end
    bus_write(4'hC, 32'h1, 4'hF);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL per_clear: got %0b want 0", irq_o); else pass_cnt++;
    for (int i = 8; i <= 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if (irq_o !== (i == 10)) $display("FAIL per_irq2_c%0d: got %0b want %0b", i, irq_o, (i == 10));
      else pass_cnt++;
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic ak;
    do_reset();
    bus_write(4'h4, 32'd2, 4'hF);
    bus_write(4'h8, 32'd2, 4'hF);
    bus_write(4'h0, 32'h0301, 4'hF);
    for (int k = 1; k <= 7; k++) begin
      bus_read(4'hC, 4'hF, d, ak);
      total_cnt++;
      if (d !== ((k == 7) ? 32'h1 : 32'h0)) $display("FAIL os_pend_clk%0d: got %h want %0d", 2 * k, d, (k == 7));
      else pass_cnt++;
    end
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL os_irq_masked: got %0b want 0", irq_o); else pass_cnt++;
    bus_read(4'h0, 4'hF, d, ak);
    total_cnt++; if (d !== 32'h0300) $display("FAIL os_ctrl: got %h want 00000300", d); else pass_cnt++;
    bus_read(4'h8, 4'hF, d, ak);
    total_cnt++; if (d !== 32'h0) $display("FAIL os_count: got %h want 0", d); else pass_cnt++;
    repeat (20) @(negedge clk);
    bus_write(4'hC, 32'h1, 4'hF);
    repeat (20) @(negedge clk);
    bus_read(4'hC, 4'hF, d, ak);
    total_cnt++; if (d !== 32'h0) $display("FAIL os_no_refire: got %h want 0", d); else pass_cnt++;
  endtask

  task automatic test_lanes();
    logic [31:0] d;
    logic ak;
    do_reset();
    bus_write(4'h4, 32'hAABBCCDD, 4'b0001);
    bus_read(4'h4, 4'hF, d, ak);
    total_cnt++; if (d !== 32'h000000DD) $display("FAIL lane_wr_b0: got %h want 000000dd", d); else pass_cnt++;
    bus_read(4'h4, 4'b0010, d, ak);
    total_cnt++; if (d !== 32'h0) $display("FAIL lane_rd_b1: got %h want 0", d); else pass_cnt++;
    bus_write(4'h4, 32'h11223344, 4'b1100);
    bus_read(4'h4, 4'hF, d, ak);
    total_cnt++; if (d !== 32'h112200DD) $display("FAIL lane_wr_b23: got %h want 112200dd", d); else pass_cnt++;
    bus_read(4'h4, 4'b1001, d, ak);
    total_cnt++; if (d !== 32'h110000DD) $display("FAIL lane_rd_b03: got %h want 110000dd", d); else pass_cnt++;
  endtask

  task automatic test_set_wins();
    do_reset();
    bus_write(4'h4, 32'd1, 4'hF);
    bus_write(4'h8, 32'd1, 4'hF);
    bus_write(4'h0, 32'h7, 4'hF);
    bus_write(4'hC, 32'h1, 4'hF);
    total_cnt++; if (irq_o !== 1'b1) $display("FAIL setwin_irq: got %0b want 1", irq_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (irq_o !== 1'b1) $display("FAIL setwin_hold: got %0b want 1", irq_o); else pass_cnt++;
    bus_write(4'hC, 32'h1, 4'hF);
    total_cnt++; if (irq_o !== 1'b0) $display("FAIL setwin_clear: got %0b want 0", irq_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (irq_o !== 1'b1) $display("FAIL setwin_refire: got %0b want 1", irq_o); else pass_cnt++;
  endtask

  task automatic test_single_read();
    do_reset();
    bus_write(4'h8, 32'h1234, 4'hF);
    @(negedge clk);
    adr_i = 4'h8; sel_i = 4'hF; we_i = 1'b0; stb_i = 1'b1;
    #1;
    total_cnt++; if (ack_o !== 1'b0) $display("FAIL sr_no_early_ack: got %0b want 0", ack_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ack_o !== 1'b1) $display("FAIL sr_ack: got %0b want 1", ack_o); else pass_cnt++;
    total_cnt++; if (dat_o !== 32'h1234) $display("FAIL sr_dat: got %h want 00001234", dat_o); else pass_cnt++;
    stb_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (ack_o !== 1'b0) $display("FAIL sr_ack_drop: got %0b want 0", ack_o); else pass_cnt++;
    total_cnt++; if (dat_o !== 32'h1234) $display("FAIL sr_dat_hold: got %h want 00001234", dat_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ack_o !== 1'b0) $display("FAIL sr_no_second_ack: got %0b want 0", ack_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_write(4'h8, 32'h55, 4'hF);
    @(negedge clk);
    adr_i = 4'h8; sel_i = 4'hF; we_i = 1'b0; stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (ack_o !== ((i % 2) == 0)) $display("FAIL b2b_ack_c%0d: got %0b want %0b", i, ack_o, ((i % 2) == 0));
      else pass_cnt++;
    end
    total_cnt++; if (dat_o !== 32'h55) $display("FAIL b2b_dat: got %h want 00000055", dat_o); else pass_cnt++;
    stb_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; stb_i = 1'b0; we_i = 1'b0;
    adr_i = 4'h0; sel_i = 4'h0; dat_i = 32'h0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_lanes();
    test_set_wins();
    test_single_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
